// File: rtl/fp_op_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : fp_op_sequencer_pkg                                          |
// | Description : Register map, CTRL/STATUS bit positions and FSM state type   |
// |               shared by the FP operation sequencer.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp_op_sequencer_pkg;

    localparam logic [2:0] c_ADDR_OPA    = 3'd0;
    localparam logic [2:0] c_ADDR_OPB    = 3'd1;
    localparam logic [2:0] c_ADDR_CTRL   = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS = 3'd3;
    localparam logic [2:0] c_ADDR_RESULT = 3'd4;

    localparam int c_CTRL_IRQ_EN_BIT = 8;
    localparam int c_CTRL_GO_BIT     = 31;

    localparam int c_ST_BUSY_BIT     = 0;
    localparam int c_ST_DONE_BIT     = 1;
    localparam int c_ST_TIMEOUT_BIT  = 2;
    localparam int c_ST_OVERRUN_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_op_timeout_ctr.sv
// +----------------------------------------------------------------------------+
// | Module      : fp_op_timeout_ctr                                            |
// | Description : Wait-cycle counter; flags the last permitted wait cycle.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_op_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TERMINAL = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == c_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/fp_op_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : fp_op_sequencer                                              |
// | Description : Avalon-slave register block that issues one FP operation per |
// |               GO, waits for completion or timeout and raises an interrupt. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_op_sequencer
    import fp_op_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int OP_W           = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            irq,
    output logic [31:0]     fpu_dataa,
    output logic [31:0]     fpu_datab,
    output logic [OP_W-1:0] fpu_op,
    output logic            fpu_start,
    input  logic            fpu_done,
    input  logic [31:0]     fpu_result
);

    state_t          r_state;
    logic [31:0]     r_opa;
    logic [31:0]     r_opb;
    logic [31:0]     r_result;
    logic [OP_W-1:0] r_opcode;
    logic            r_irq_en;
    logic            r_done;
    logic            r_timeout;
    logic            r_overrun;
    logic            r_fpu_start;
    logic            r_irq;

    logic w_wr;
    logic w_busy;
    logic w_in_wait;
    logic w_terminal;
    logic w_wr_ctrl;
    logic w_go_idle;
    logic w_go_busy;
    logic w_wr_status;
    logic w_complete;
    logic w_expire;
    logic w_done_nxt;
    logic w_timeout_nxt;
    logic w_overrun_nxt;
    logic w_irq_en_nxt;

    assign w_wr        = chipselect & ~write_n;
    assign w_busy      = (r_state != ST_IDLE);
    assign w_in_wait   = (r_state == ST_WAIT);
    assign w_wr_ctrl   = w_wr && (address == c_ADDR_CTRL);
    assign w_go_idle   = w_wr_ctrl && writedata[c_CTRL_GO_BIT] && !w_busy;
    assign w_go_busy   = w_wr_ctrl && writedata[c_CTRL_GO_BIT] && w_busy;
    assign w_wr_status = w_wr && (address == c_ADDR_STATUS);
    // A completion on the terminal cycle takes priority over the timeout.
    assign w_complete  = w_in_wait && fpu_done;
    assign w_expire    = w_in_wait && !fpu_done && w_terminal;

    fp_op_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (r_state == ST_ISSUE),
        .i_enable   (w_in_wait && !fpu_done),
        .o_terminal (w_terminal)
    );

    // Sticky flags: GO clears, write-1 clears, and a same-cycle set wins.
    always_comb begin
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;
        w_overrun_nxt = r_overrun;
        w_irq_en_nxt  = r_irq_en;
        if (w_go_idle) begin
            w_done_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
            w_overrun_nxt = 1'b0;
        end else if (w_wr_status) begin
            if (writedata[c_ST_DONE_BIT])    w_done_nxt    = 1'b0;
            if (writedata[c_ST_TIMEOUT_BIT]) w_timeout_nxt = 1'b0;
            if (writedata[c_ST_OVERRUN_BIT]) w_overrun_nxt = 1'b0;
        end
        if (w_complete || w_expire) w_done_nxt    = 1'b1;
        if (w_expire)               w_timeout_nxt = 1'b1;
        if (w_go_busy)              w_overrun_nxt = 1'b1;
        if (w_wr_ctrl && !w_busy)   w_irq_en_nxt  = writedata[c_CTRL_IRQ_EN_BIT];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_opcode    <= '0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
            r_fpu_start <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
            r_overrun   <= w_overrun_nxt;
            r_irq_en    <= w_irq_en_nxt;
            r_irq       <= w_done_nxt & w_irq_en_nxt;
            r_fpu_start <= 1'b0;

            if (w_wr && (address == c_ADDR_OPA) && !w_busy) r_opa <= writedata;
            if (w_wr && (address == c_ADDR_OPB) && !w_busy) r_opb <= writedata;
            if (w_wr_ctrl && !w_busy) r_opcode <= writedata[OP_W-1:0];
            if (w_complete) r_result <= fpu_result;

            case (r_state)
                ST_IDLE: begin
                    if (w_go_idle) begin
                        r_state     <= ST_ISSUE;
                        r_fpu_start <= 1'b1;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_complete || w_expire) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            c_ADDR_OPA:    readdata = r_opa;
            c_ADDR_OPB:    readdata = r_opb;
            c_ADDR_CTRL: begin
                readdata[OP_W-1:0]         = r_opcode;
                readdata[c_CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            c_ADDR_STATUS: begin
                readdata[c_ST_BUSY_BIT]    = w_busy;
                readdata[c_ST_DONE_BIT]    = r_done;
                readdata[c_ST_TIMEOUT_BIT] = r_timeout;
                readdata[c_ST_OVERRUN_BIT] = r_overrun;
            end
            c_ADDR_RESULT: readdata = r_result;
            default:       readdata = '0;
        endcase
    end

    assign fpu_dataa = r_opa;
    assign fpu_datab = r_opb;
    assign fpu_op    = r_opcode;
    assign fpu_start = r_fpu_start;
    assign irq       = r_irq;

endmodule

`default_nettype wire
